sqrt_iter_n: RTL and testbench

Parametrised, handshaked, iterative square-root unit for the custom float format: unbiased signed exponent, explicit-leading-one mantissa, and separate NaN/±Inf flags. It computes one or two root bits per cycle with a restoring digit recurrence and applies round-to-nearest-even. It adds valid/ready flow control with output backpressure and an inexact flag. It sits between the operand-unpack stage and the result-pack stage of the FP datapath.

---
 rtl/sqrt_iter_n.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sqrt_iter_n.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_n.sv
// -----------------------------------------------------------------------------
// sqrt_iter_n
// Iterative square root for the custom float format. The format uses an
// unbiased signed exponent and a mantissa with an explicit leading one. NaN and
// +/-Inf are carried as separate flags. The unit runs a restoring digit
// recurrence that produces BPC root bits per cycle, then rounds the result to
// nearest, ties to even.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         operand handshake
//   in_sign, in_exp, in_mant    operand
//   in_nan, in_pinf, in_ninf,   operand class (in_num = 0 is treated as NaN)
//   in_num
//   out_valid / out_ready       result handshake (outputs held while stalled)
//   out_sign, out_exp, out_mant result
//   out_nan, out_pinf, out_ninf result class
//   out_inexact                 nonzero remainder or nonzero guard bit
//   busy                        unit is not idle
// -----------------------------------------------------------------------------
module sqrt_iter_n #(
    parameter int MANT_W   = 11,
    parameter int EXP_W    = 7,
    parameter int EXP_ZERO = -15,
    parameter int EXP_SPEC = 16,
    parameter int BPC      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    input  logic                    in_nan,
    input  logic                    in_pinf,
    input  logic                    in_ninf,
    input  logic                    in_num,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic signed [EXP_W-1:0] out_exp,
    output logic [MANT_W-1:0]       out_mant,
    output logic                    out_nan,
    output logic                    out_pinf,
    output logic                    out_ninf,
    output logic                    out_inexact,
    output logic                    busy
);

    localparam int W1 = MANT_W + 1;             // root width: mantissa plus guard bit
    localparam int N  = (W1 + BPC - 1) / BPC;   // CALC cycles
    localparam int S  = N * BPC;                // recurrence steps, >= W1
    localparam int RW = W1 + 3;                 // remainder width with headroom
    localparam int CW = $clog2(N + 1);

    if (BPC != 1 && BPC != 2) begin : g_bad_bpc
        $error("sqrt_iter_n: BPC must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
    typedef enum logic [2:0] {CLS_NAN, CLS_NEG, CLS_PINF, CLS_ZERO, CLS_NUM} cls_t;
    typedef struct packed {
        logic [RW-1:0] rem;
        logic [S-1:0]  root;
    } step_t;

    // One restoring step: trial = (rem<<2 | bits) - (root<<2 | 1); keep it if >= 0.
    function automatic step_t sqrt_step(input step_t cur, input logic [1:0] bits);
        step_t         nxt;
        logic [RW+2:0] trial;
        trial = {1'b0, cur.rem, bits} - (RW+3)'({cur.root, 2'b01});
        if (!trial[RW+2]) begin
            nxt.rem  = RW'(trial);
            nxt.root = S'({cur.root, 1'b1});
        end else begin
            nxt.rem  = RW'({cur.rem, bits});
            nxt.root = S'({cur.root, 1'b0});
        end
        return nxt;
    endfunction

    state_t                    state_q, state_d;
    logic [2*S-1:0]            rad_q;
    logic [S-1:0]              root_q;
    logic [RW-1:0]             rem_q;
    logic [CW-1:0]             cnt_q;
    logic signed [EXP_W-1:0]   exp_q;

    logic                      out_sign_q, out_nan_q, out_pinf_q, out_ninf_q, out_inexact_q;
    logic signed [EXP_W-1:0]   out_exp_q;
    logic [MANT_W-1:0]         out_mant_q;

    logic                      accept;
    cls_t                      cls;
    logic                      in_special;
    logic                      spec_sign, spec_nan, spec_pinf;
    logic signed [EXP_W-1:0]   spec_exp;
    logic [MANT_W-1:0]         spec_mant;
    logic [W1-1:0]             radicand;
    logic [2*S-1:0]            rad_init;
    step_t                     s0, s1, calc_res;
    logic [W1-1:0]             root_w;
    logic                      guard, sticky, round_up;
    logic [MANT_W:0]           mant_sum;
    logic [MANT_W-1:0]         rnd_mant;
    logic signed [EXP_W-1:0]   rnd_exp;

    assign accept = in_valid & in_ready;

    // Operand classification and special-case results.
    always_comb begin
        // NOTE: every variable written here gets a default first so that no path leaves it unassigned and infers a latch.
        cls       = CLS_NUM;
        spec_sign = 1'b0;
        spec_nan  = 1'b0;
        spec_pinf = 1'b0;
        spec_exp  = EXP_W'(EXP_SPEC);
        spec_mant = '0;
        if (in_nan || !in_num)
            cls = CLS_NAN;
        else if (in_ninf || (in_sign && !in_pinf &&
                 !((in_exp == EXP_W'(EXP_ZERO)) && (in_mant == '0))))
            cls = CLS_NEG;
        else if (in_pinf)
            cls = CLS_PINF;
        else if ((in_exp == EXP_W'(EXP_ZERO)) && (in_mant == '0))
            cls = CLS_ZERO;

        case (cls)
            CLS_NAN: begin
                spec_sign = in_sign;
                spec_nan  = 1'b1;
                spec_mant = in_mant | (MANT_W'(1) << (MANT_W - 2));   // force quiet bit
            end
            CLS_NEG: begin
                spec_sign = 1'b1;
                spec_nan  = 1'b1;
                spec_mant = {2'b11, {(MANT_W-2){1'b0}}};
            end
            CLS_PINF: spec_pinf = 1'b1;
            CLS_ZERO: begin
                spec_sign = in_sign;
                spec_exp  = EXP_W'(EXP_ZERO);
            end
            default: ;
        endcase
        in_special = (cls != CLS_NUM);
    end

    // An odd exponent folds one factor of two into the radicand. The radicand
    // is left-aligned, so the recurrence always consumes it from the top.
    always_comb begin
        radicand = in_exp[0] ? {in_mant, 1'b0} : {1'b0, in_mant};
        rad_init = (2*S)'({radicand, {W1{1'b0}}});
    end

    always_comb begin
        s0       = sqrt_step({rem_q, root_q}, rad_q[2*S-1 -: 2]);
        s1       = sqrt_step(s0, rad_q[2*S-3 -: 2]);
        calc_res = (BPC == 2) ? s1 : s0;
    end

    // Round to nearest even: the guard bit is root[0] and the sticky bit is the remainder.
    always_comb begin
        root_w   = root_q[W1-1:0];
        guard    = root_w[0];
        sticky   = |rem_q;
        round_up = guard & (sticky | root_w[1]);
        mant_sum = {1'b0, root_w[W1-1:1]} + (MANT_W+1)'(round_up);
        rnd_mant = mant_sum[MANT_W-1:0];
        rnd_exp  = exp_q;
        if (mant_sum[MANT_W]) begin
            rnd_mant = {1'b1, {(MANT_W-1){1'b0}}};
            rnd_exp  = exp_q + EXP_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = in_special ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE: begin
                if (accept)         state_d = in_special ? DONE : CALC;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath. The result registers load only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q         <= '0;
            root_q        <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            exp_q         <= '0;
            out_sign_q    <= 1'b0;
            out_exp_q     <= '0;
            out_mant_q    <= '0;
            out_nan_q     <= 1'b0;
            out_pinf_q    <= 1'b0;
            out_ninf_q    <= 1'b0;
            out_inexact_q <= 1'b0;
        end else if (accept) begin
            rad_q  <= rad_init;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= CW'(N);
            exp_q  <= in_exp >>> 1;
            if (in_special) begin
                out_sign_q    <= spec_sign;
                out_exp_q     <= spec_exp;
                out_mant_q    <= spec_mant;
                out_nan_q     <= spec_nan;
                out_pinf_q    <= spec_pinf;
                out_ninf_q    <= 1'b0;
                out_inexact_q <= 1'b0;
            end
        end else if (state_q == CALC) begin
            rad_q  <= rad_q << (2 * BPC);
            root_q <= calc_res.root;
            rem_q  <= calc_res.rem;
            cnt_q  <= cnt_q - CW'(1);
        end else if (state_q == ROUND) begin
            out_sign_q    <= 1'b0;
            out_exp_q     <= rnd_exp;
            out_mant_q    <= rnd_mant;
            out_nan_q     <= 1'b0;
            out_pinf_q    <= 1'b0;
            out_ninf_q    <= 1'b0;
            out_inexact_q <= guard | sticky;
        end
    end

    assign out_sign    = out_sign_q;
    assign out_exp     = out_exp_q;
    assign out_mant    = out_mant_q;
    assign out_nan     = out_nan_q;
    assign out_pinf    = out_pinf_q;
    assign out_ninf    = out_ninf_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_sqrt_iter_n.sv
// -----------------------------------------------------------------------------
// tb_sqrt_iter_n
// Runs two instances of sqrt_iter_n, one with BPC=1 and one with BPC=2, through
// directed cases, backpressure, a mid-operation reset and a random sweep of
// normal operands. Every result is compared against an arithmetic model that
// rounds the exact square root to nearest even.
// -----------------------------------------------------------------------------
module tb_sqrt_iter_n;

    localparam int MW = 11;
    localparam int EW = 7;
    localparam logic signed [EW-1:0] E_SPEC = 7'sd16;
    localparam logic signed [EW-1:0] E_ZERO = -7'sd15;
    localparam int N_RAND = 2000;

    // {sign, exp, mant, nan, pinf, ninf, inexact}
    typedef logic [22:0] res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 in_valid[2], in_ready[2], in_sign[2];
    logic signed [EW-1:0] in_exp[2];
    logic [MW-1:0]        in_mant[2];
    logic                 in_nan[2], in_pinf[2], in_ninf[2], in_num[2];
    logic                 out_valid[2], out_ready[2], out_sign[2];
    logic signed [EW-1:0] out_exp[2];
    logic [MW-1:0]        out_mant[2];
    logic                 out_nan[2], out_pinf[2], out_ninf[2], out_inexact[2], busy[2];

    sqrt_iter_n #(.BPC(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_sign(in_sign[0]), .in_exp(in_exp[0]), .in_mant(in_mant[0]),
        .in_nan(in_nan[0]), .in_pinf(in_pinf[0]), .in_ninf(in_ninf[0]), .in_num(in_num[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sign(out_sign[0]), .out_exp(out_exp[0]), .out_mant(out_mant[0]),
        .out_nan(out_nan[0]), .out_pinf(out_pinf[0]), .out_ninf(out_ninf[0]),
        .out_inexact(out_inexact[0]), .busy(busy[0])
    );

    sqrt_iter_n #(.BPC(2)) u_bpc2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_sign(in_sign[1]), .in_exp(in_exp[1]), .in_mant(in_mant[1]),
        .in_nan(in_nan[1]), .in_pinf(in_pinf[1]), .in_ninf(in_ninf[1]), .in_num(in_num[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sign(out_sign[1]), .out_exp(out_exp[1]), .out_mant(out_mant[1]),
        .out_nan(out_nan[1]), .out_pinf(out_pinf[1]), .out_ninf(out_ninf[1]),
        .out_inexact(out_inexact[1]), .busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic res_t mk(input logic s, input logic signed [EW-1:0] e, input logic [MW-1:0] m,
                                input logic nan, input logic pinf, input logic ninf, input logic inx);
        return {s, e, m, nan, pinf, ninf, inx};
    endfunction

    function automatic res_t obs(input int k);
        return {out_sign[k], out_exp[k], out_mant[k], out_nan[k], out_pinf[k], out_ninf[k], out_inexact[k]};
    endfunction

    function automatic longint isqrt(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Reference: classify the operand, then take the exact square root of
    // mant * 2^(exp-10) and round it to an 11-bit mantissa, ties to even.
    function automatic res_t ref_sqrt(input logic s, input logic signed [EW-1:0] e, input logic [MW-1:0] m,
                                      input logic nan, input logic pinf, input logic ninf, input logic num);
        logic   is_zero;
        int     ei, par, eo;
        longint x, m0, q, mid;
        logic   inx;
        is_zero = (e == E_ZERO) && (m == '0);
        if (nan || !num)                    return mk(s, E_SPEC, m | 11'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        if (ninf || (s && !pinf && !is_zero)) return mk(1'b1, E_SPEC, 11'h600, 1'b1, 1'b0, 1'b0, 1'b0);
        if (pinf)                           return mk(1'b0, E_SPEC, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        if (is_zero)                        return mk(s, E_ZERO, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        ei  = int'(e);
        par = ei & 1;
        eo  = (ei - par) / 2;
        // The value is sqrt(x)/2 * 2^(eo-10), so the mantissa is close to sqrt(x)/2.
        x   = longint'(m) << (12 + par);
        m0  = isqrt(x >> 2);
        mid = (2 * m0 + 1) * (2 * m0 + 1);
        q   = m0;
        if (x > mid || (x == mid && (m0 % 2) == 1)) q = m0 + 1;
        inx = (x != 4 * m0 * m0);
        if (q == 2048) begin
            q  = 1024;
            eo = eo + 1;
        end
        return mk(1'b0, EW'(eo), MW'(q), 1'b0, 1'b0, 1'b0, inx);
    endfunction

    task automatic set_op(input int k, input logic s, input logic signed [EW-1:0] e, input logic [MW-1:0] m,
                          input logic nan, input logic pinf, input logic ninf, input logic num);
        in_sign[k] = s;   in_exp[k]  = e;    in_mant[k] = m;
        in_nan[k]  = nan; in_pinf[k] = pinf; in_ninf[k] = ninf; in_num[k] = num;
    endtask

    // Present an operand for one edge, then scramble the inputs. The DUT must
    // capture the operand on the accept edge only.
    task automatic drive(input int k, input logic s, input logic signed [EW-1:0] e, input logic [MW-1:0] m,
                         input logic nan, input logic pinf, input logic ninf, input logic num);
        set_op(k, s, e, m, nan, pinf, ninf, num);
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        set_op(k, 1'($urandom), EW'($urandom), MW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // lat = index of the first edge (accept edge = 0) that samples out_valid high.
    task automatic wait_out(input int k, output int lat);
        lat = 1;
        while (!out_valid[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", 64'(out_valid[k]), 64'd1);
    endtask

    task automatic run(input int k, input string tag, input logic s, input logic signed [EW-1:0] e,
                       input logic [MW-1:0] m, input logic nan, input logic pinf, input logic ninf,
                       input logic num, input res_t want, input int want_lat);
        int lat;
        drive(k, s, e, m, nan, pinf, ninf, num);
        wait_out(k, lat);
        check({tag, "_res"}, 64'(obs(k)), 64'(want));
        if (want_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(want_lat));
        @(posedge clk); #1;   // out_ready is high, so the result is consumed here
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r4, r2, rn2, w;
        int   lat, nlat;
        logic signed [EW-1:0] e;
        logic [MW-1:0] m;

        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b1;
            set_op(k, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Reset state
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 64'(out_valid[k]), 64'd0);
            check("rst_busy",      64'(busy[k]),      64'd0);
            check("rst_in_ready",  64'(in_ready[k]),  64'd1);
            check("rst_result",    64'(obs(k)),       64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        r4  = mk(1'b0, 7'sd1,  11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        r2  = mk(1'b0, 7'sd0,  11'h5A8, 1'b0, 1'b0, 1'b0, 1'b1);
        rn2 = mk(1'b0, -7'sd1, 11'h5A8, 1'b0, 1'b0, 1'b0, 1'b1);

        // Directed numeric and special cases on both instances
        for (int k = 0; k < 2; k++) begin
            nlat = (k == 0) ? 14 : 8;
            run(k, "sqrt4",  1'b0, 7'sd2,  11'h400, 1'b0, 1'b0, 1'b0, 1'b1, r4,  nlat);
            run(k, "sqrt2",  1'b0, 7'sd1,  11'h400, 1'b0, 1'b0, 1'b0, 1'b1, r2,  nlat);
            run(k, "sqrt_half", 1'b0, -7'sd1, 11'h400, 1'b0, 1'b0, 1'b0, 1'b1, rn2, nlat);
            run(k, "ninf",   1'b1, 7'sd0,  11'h000, 1'b0, 1'b0, 1'b1, 1'b1,
                mk(1'b1, E_SPEC, 11'h600, 1'b1, 1'b0, 1'b0, 1'b0), 1);
            run(k, "neg_num", 1'b1, 7'sd0, 11'h400, 1'b0, 1'b0, 1'b0, 1'b1,
                mk(1'b1, E_SPEC, 11'h600, 1'b1, 1'b0, 1'b0, 1'b0), 1);
            run(k, "pinf",   1'b0, 7'sd0,  11'h000, 1'b0, 1'b1, 1'b0, 1'b1,
                mk(1'b0, E_SPEC, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0), 1);
            run(k, "neg_zero", 1'b1, E_ZERO, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1,
                mk(1'b1, E_ZERO, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0), 1);
            run(k, "qnan",   1'b0, 7'sd3,  11'h123, 1'b1, 1'b0, 1'b0, 1'b1,
                mk(1'b0, E_SPEC, 11'h323, 1'b1, 1'b0, 1'b0, 1'b0), 1);
            run(k, "not_num", 1'b1, 7'sd5, 11'h500, 1'b0, 1'b0, 1'b0, 1'b0,
                mk(1'b1, E_SPEC, 11'h700, 1'b1, 1'b0, 1'b0, 1'b0), 1);
        end

        // Backpressure: hold DONE for 5 cycles while a +Inf operand is offered and must be ignored
        out_ready[0] = 1'b0;
        drive(0, 1'b0, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_out(0, lat);
        check("bp_result", 64'(obs(0)), 64'(r4));
        set_op(0, 1'b0, 7'sd0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold",      64'(obs(0)),        64'(r4));
            check("bp_out_valid", 64'(out_valid[0]),  64'd1);
            check("bp_in_ready",  64'(in_ready[0]),   64'd0);
        end
        set_op(0, 1'b0, 7'sd1, 11'h400, 1'b0, 1'b0, 1'b0, 1'b1);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        set_op(0, 1'b1, 7'sd9, 11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_reload_busy",  64'(busy[0]),      64'd1);
        check("bp_reload_valid", 64'(out_valid[0]), 64'd0);
        wait_out(0, lat);
        check("bp_next_res", 64'(obs(0)), 64'(r2));
        check("bp_next_lat", 64'(lat),    64'd14);
        @(posedge clk); #1;

        // Reset at CALC cycle 5 aborts; a fresh operand afterwards must be clean
        drive(0, 1'b0, 7'sd5, 11'h7FF, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
        check("mid_rst_busy",  64'(busy[0]),      64'd0);
        check("mid_rst_res",   64'(obs(0)),       64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(out_valid[0]), 64'd0);
        run(0, "post_rst_sqrt9", 1'b0, 7'sd3, 11'h480, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(1'b0, 7'sd1, 11'h600, 1'b0, 1'b0, 1'b0, 1'b0), 14);

        // Random sweep of normal operands against the reference model
        for (int k = 0; k < 2; k++) begin
            nlat = (k == 0) ? 14 : 8;
            for (int i = 0; i < N_RAND; i++) begin
                e = EW'($urandom_range(0, 127));
                m = MW'(11'h400 | $urandom_range(0, 1023));
                w = ref_sqrt(1'b0, e, m, 1'b0, 1'b0, 1'b0, 1'b1);
                run(k, "rand", 1'b0, e, m, 1'b0, 1'b0, 1'b0, 1'b1, w, nlat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
